pattern_line_sched: RTL and testbench
=====================================

Name: pattern_line_sched

Overview:
- Frame-level sequencer for the FHD line pattern generator.
- Issues one start request per active line.
- Waits for the generator's data-enable window to open and close, then inserts horizontal and vertical blanking.
- Counts lines and frames, and latches the pattern selection only at frame boundaries so a frame never changes pattern mid-way.

Parameters:
- ACTIVE_LINES, 1080, active lines per frame.
- H_GAP, 280, idle cycles after gen_den falls before the next line request.
- V_GAP, 45000, idle cycles after the last line of a frame.
- START_W, 3, cycles gen_start is held high; must be at least 3 because the generator edge-detects start through two flops.
- TMO, 15, max cycles to wait for gen_den to rise after gen_start falls.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = generate frames.
- n_frames  in  8  frames to emit per run rising edge; 0 = continuous.
- pat_sel_in  in  2  requested pattern.
- gen_den  in  1  generator data enable.
- gen_start  out  1  start request to generator.
- pat_sel  out  2  pattern applied to the current frame.
- line_cnt  out  11  current line index, 0..ACTIVE_LINES-1.
- frame_cnt  out  8  frames completed in this run.
- first_line  out  1  high while line 0 is being requested or active.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of each frame's vertical gap.
- err  out  1  sticky timeout flag.

Behaviour:
- Timing:
  - One clock: clock. Reset is asynchronous and active-high on port reset.
  - All outputs are registered.
- Reset values:
  - state = IDLE.
  - All outputs 0: gen_start, pat_sel, line_cnt, frame_cnt, first_line, busy, frame_done, err.
  - All internal counters 0.
  - Asserting reset mid-frame aborts immediately. gen_start drops in the same cycle it is asserted (asynchronous).
- run handling: run is sampled into a registered edge detector; run_rise = run & ~run_d.
- State machine:
  - IDLE: on run_rise:
    - pat_sel <= pat_sel_in; frame_cnt <= 0; line_cnt <= 0; err is not cleared.
    - Latch n_frames into frames_left.
    - Go to START.
  - START:
    - gen_start = 1 for exactly START_W cycles, then go to WAIT_HI.
    - gen_start is 0 in all other states.
  - WAIT_HI:
    - gen_den = 1 -> ACTIVE.
    - If the wait counter reaches TMO with no gen_den -> err <= 1, go to IDLE.
  - ACTIVE: on gen_den falling (registered compare), go to HBLANK.
  - HBLANK: count H_GAP cycles, then:
    - If line_cnt == ACTIVE_LINES-1: line_cnt <= 0, go to VBLANK.
    - Else: line_cnt <= line_cnt+1, go to START.
  - VBLANK: after V_GAP cycles:
    - frame_done pulses for 1 cycle; frame_cnt <= frame_cnt+1 (wraps 255->0).
    - pat_sel <= pat_sel_in.
    - Then go to START, unless one of the stop conditions below applies (-> IDLE).
- Stop conditions:
  - run = 0 while busy: the current line completes through HBLANK. Then go to VBLANK, skipping the remaining lines. After VBLANK -> IDLE, with frame_done still pulsed.
  - n_frames != 0 and frame_cnt+1 == frames_left at the end of VBLANK -> IDLE. Further frames require a new run_rise.
  - n_frames == 0: frames continue until run = 0.
- first_line = busy & (line_cnt == 0) & state in {START, WAIT_HI, ACTIVE}.
- Boundaries:
  - run_rise while busy is ignored.
  - pat_sel_in changes mid-frame are ignored until VBLANK exit.
  - gen_den staying high is never timed out.
  - gen_den = 1 already on START entry: do not advance until START_W completes.
  - err clears only on reset.
- Line period = START_W + generator latency + gen_den width + 1 + H_GAP.

Test Plan:
- Basic frame:
  - Stimulus: reset, then run 0->1 with n_frames = 1, pat_sel_in = 2. Generator model raises gen_den 4 cycles after start and holds it 1920 cycles.
  - Required: 1080 gen_start pulses, each 3 cycles wide; pat_sel = 2; one frame_done; frame_cnt = 1; busy drops; IDLE.
- Pattern latch:
  - Stimulus: n_frames = 2; change pat_sel_in 2->1 at line 500 of frame 0.
  - Required: pat_sel = 2 for all of frame 0 and changes to 1 in the frame_done cycle.
- Timeout:
  - Stimulus: generator model never raises gen_den.
  - Required: err = 1 exactly TMO+1 cycles after gen_start falls; state IDLE; busy = 0; err stays 1 across a new run_rise.
- Early stop:
  - Stimulus: n_frames = 0; drop run at line 10.
  - Required: line 10 completes; no further gen_start; after V_GAP, frame_done pulses and busy = 0.
- Async reset:
  - Stimulus: assert reset during a START window.
  - Required: gen_start and busy drop in the same cycle; all outputs 0; a new run_rise restarts at line 0.
- Continuous wrap:
  - Stimulus: n_frames = 0 with a shortened V_GAP; run 257 frames.
  - Required: frame_cnt wraps 255->0; line_cnt never exceeds 1079.

Source files
------------

// File: rtl/pattern_line_sched.sv
// Frame-level sequencer for the line pattern generator: requests one line at a time,
// inserts horizontal/vertical blanking, counts lines/frames and latches the pattern per frame.
module pattern_line_sched #(
    parameter int ACTIVE_LINES = 1080,
    parameter int H_GAP        = 280,
    parameter int V_GAP        = 45000,
    parameter int START_W      = 3,
    parameter int TMO          = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  n_frames,
    input  logic [1:0]  pat_sel_in,
    input  logic        gen_den,
    output logic        gen_start,
    output logic [1:0]  pat_sel,
    output logic [10:0] line_cnt,
    output logic [7:0]  frame_cnt,
    output logic        first_line,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);
    localparam int M1      = (V_GAP > H_GAP) ? V_GAP : H_GAP;
    localparam int M2      = (M1 > START_W) ? M1 : START_W;
    localparam int CNT_MAX = (M2 > TMO + 1) ? M2 : TMO + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_HI, ACTIVE, HBLANK, VBLANK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          run_d, den_d, stop, stop_n;
    logic [7:0]    frames_left, frames_left_n;
    logic [10:0]   line_n;
    logic [7:0]    frame_n;
    logic [1:0]    pat_n;
    logic          err_n, frame_done_n, gen_start_n, busy_n, first_line_n;
    logic          run_rise, stop_now;

    assign run_rise = run & ~run_d;
    // A run drop is remembered so a short low pulse still ends the frame early.
    assign stop_now = stop | ~run;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            run_d       <= 1'b0;
            den_d       <= 1'b0;
            stop        <= 1'b0;
            frames_left <= '0;
            gen_start   <= 1'b0;
            pat_sel     <= '0;
            line_cnt    <= '0;
            frame_cnt   <= '0;
            first_line  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            run_d       <= run;
            den_d       <= gen_den;
            stop        <= stop_n;
            frames_left <= frames_left_n;
            gen_start   <= gen_start_n;
            pat_sel     <= pat_n;
            line_cnt    <= line_n;
            frame_cnt   <= frame_n;
            first_line  <= first_line_n;
            busy        <= busy_n;
            frame_done  <= frame_done_n;
            err         <= err_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt + CW'(1);
        line_n        = line_cnt;
        frame_n       = frame_cnt;
        pat_n         = pat_sel;
        frames_left_n = frames_left;
        err_n         = err;
        frame_done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (run_rise) begin
                    pat_n         = pat_sel_in;
                    frame_n       = '0;
                    line_n        = '0;
                    frames_left_n = n_frames;
                    state_n       = START;
                end
            end
            START: begin
                // gen_den is deliberately ignored until the full start pulse has gone out.
                if (cnt == CW'(START_W - 1)) begin
                    cnt_n   = '0;
                    state_n = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (gen_den) begin
                    cnt_n   = '0;
                    state_n = ACTIVE;
                end else if (cnt == CW'(TMO)) begin
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            ACTIVE: begin
                cnt_n = '0;
                if (den_d && !gen_den) state_n = HBLANK;
            end
            HBLANK: begin
                if (cnt == CW'(H_GAP - 1)) begin
                    cnt_n = '0;
                    if (line_cnt == 11'(ACTIVE_LINES - 1) || stop_now) begin
                        line_n  = '0;
                        state_n = VBLANK;
                    end else begin
                        line_n  = line_cnt + 11'd1;
                        state_n = START;
                    end
                end
            end
            VBLANK: begin
                if (cnt == CW'(V_GAP - 1)) begin
                    cnt_n        = '0;
                    frame_done_n = 1'b1;
                    frame_n      = frame_cnt + 8'd1;
                    pat_n        = pat_sel_in;
                    if (stop_now || (frames_left != 8'd0 && frame_n == frames_left))
                        state_n = IDLE;
                    else
                        state_n = START;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        stop_n       = (state != IDLE) && (state_n != IDLE) && stop_now;
        gen_start_n  = (state_n == START);
        busy_n       = (state_n != IDLE);
        first_line_n = (state_n == START || state_n == WAIT_HI || state_n == ACTIVE)
                       && (line_n == 11'd0);
    end
endmodule

// File: tb/tb_pattern_line_sched.sv
// Directed bench for pattern_line_sched with a small generator model and a
// frame_done scoreboard holding expected {frame_cnt, pat_sel} per frame.
`timescale 1ns/1ps
module tb_pattern_line_sched;
    localparam int AL    = 8;
    localparam int HG    = 5;
    localparam int VG    = 20;
    localparam int SW    = 3;
    localparam int TMO   = 15;
    localparam int DEN_W = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  n_frames = 8'd0;
    logic [1:0]  pat_sel_in = 2'd0;
    logic        gen_den;
    logic        gen_start;
    logic [1:0]  pat_sel;
    logic [10:0] line_cnt;
    logic [7:0]  frame_cnt;
    logic        first_line, busy, frame_done, err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [9:0] exp_q[$];

    pattern_line_sched #(
        .ACTIVE_LINES(AL), .H_GAP(HG), .V_GAP(VG), .START_W(SW), .TMO(TMO)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .n_frames(n_frames),
        .pat_sel_in(pat_sel_in), .gen_den(gen_den), .gen_start(gen_start),
        .pat_sel(pat_sel), .line_cnt(line_cnt), .frame_cnt(frame_cnt),
        .first_line(first_line), .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Generator model: gen_den rises 4 cycles after gen_start rises, stays DEN_W cycles.
    bit   gen_live = 1'b1;
    int   g_cnt = 0;
    logic g_prev = 1'b0;
    initial begin
        gen_den = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (gen_start && !g_prev) g_cnt = 1;
            else if (g_cnt != 0) g_cnt++;
            g_prev  = gen_start;
            gen_den = gen_live && (g_cnt >= 5) && (g_cnt < 5 + DEN_W);
        end
    end

    // Monitor: start pulse width, start count, max line index, frame_done scoreboard.
    int   sw_len = 0;
    int   starts = 0;
    int   line_max = 0;
    logic st_prev = 1'b0;
    logic fd_prev = 1'b0;
    always @(negedge clock) begin
        if (reset) sw_len = 0;
        else if (gen_start) sw_len++;
        else if (sw_len != 0) begin
            check("start_width", sw_len, SW);
            sw_len = 0;
        end
        if (gen_start && !st_prev) starts++;
        st_prev = gen_start;
        if (int'(line_cnt) > line_max) line_max = int'(line_cnt);
        if (frame_done) begin
            check("frame_done_pulse", fd_prev, 0);
            check("frame_done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("frame_cnt_pat_sel", {frame_cnt, pat_sel}, exp_q.pop_front());
        end
        fd_prev = frame_done;
    end

    task automatic wait_line_start(input string tag, input int line, input int budget);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clock);
            if (gen_start && line_cnt == 11'(line)) hit = 1'b1;
        end
        check(tag, hit, 1);
    endtask

    task automatic wait_start_fall(input string tag, input int budget);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clock);
            if (!gen_start) hit = 1'b1;
        end
        check(tag, hit, 1);
    endtask

    task automatic wait_err(input string tag, input int budget);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clock);
            if (err) hit = 1'b1;
        end
        check(tag, hit, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clock);
            if (!busy) hit = 1'b1;
        end
        check(tag, hit, 1);
        @(negedge clock);
    endtask

    initial begin
        int s0, t0, seen;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_gen_start", gen_start, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_first_line", first_line, 0);
        check("rst_pat_sel", pat_sel, 0);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        reset = 1'b0;
        @(negedge clock);

        // Basic frame
        n_frames = 8'd1;
        pat_sel_in = 2'd2;
        exp_q.push_back({8'd1, 2'd2});
        s0 = starts;
        run = 1'b1;
        wait_line_start("b_line0", 0, 50);
        check("b_first_line0", first_line, 1);
        check("b_pat_sel", pat_sel, 2);
        t0 = cyc;
        wait_line_start("b_line1", 1, 100);
        check("b_line_period", cyc - t0, SW + 1 + DEN_W + 1 + HG);
        check("b_first_line1", first_line, 0);
        wait_idle("b_idle", 3000);
        check("b_starts", starts - s0, AL);
        check("b_frame_cnt", frame_cnt, 1);
        check("b_pat_sel_end", pat_sel, 2);
        check("b_line_cnt_end", line_cnt, 0);
        check("b_q_empty", exp_q.size(), 0);
        run = 1'b0;
        @(negedge clock);

        // Pattern latch at frame boundary
        n_frames = 8'd2;
        pat_sel_in = 2'd2;
        run = 1'b1;
        wait_line_start("p_line4", 4, 200);
        pat_sel_in = 2'd1;
        exp_q.push_back({8'd1, 2'd1});
        exp_q.push_back({8'd2, 2'd1});
        check("p_pat_hold4", pat_sel, 2);
        wait_line_start("p_line7", 7, 200);
        check("p_pat_hold7", pat_sel, 2);
        wait_idle("p_idle", 3000);
        check("p_frame_cnt", frame_cnt, 2);
        check("p_pat_sel_end", pat_sel, 1);
        check("p_q_empty", exp_q.size(), 0);
        run = 1'b0;
        @(negedge clock);

        // Timeout
        gen_live = 1'b0;
        n_frames = 8'd1;
        pat_sel_in = 2'd0;
        run = 1'b1;
        wait_line_start("t_line0", 0, 50);
        wait_start_fall("t_fall", 20);
        t0 = cyc;
        wait_err("t_err", 40);
        check("t_err_delay", cyc - t0, TMO + 1);
        check("t_busy", busy, 0);
        check("t_gen_start", gen_start, 0);
        run = 1'b0;
        gen_live = 1'b1;
        @(negedge clock);
        exp_q.push_back({8'd1, 2'd0});
        run = 1'b1;
        wait_line_start("t2_line0", 0, 50);
        check("t_err_sticky", err, 1);
        wait_idle("t2_idle", 3000);
        check("t_err_sticky_end", err, 1);
        check("t2_frame_cnt", frame_cnt, 1);
        run = 1'b0;
        @(negedge clock);

        // Early stop
        n_frames = 8'd0;
        pat_sel_in = 2'd3;
        exp_q.push_back({8'd1, 2'd3});
        s0 = starts;
        run = 1'b1;
        wait_line_start("e_line3", 3, 200);
        run = 1'b0;
        wait_idle("e_idle", 500);
        check("e_starts", starts - s0, 4);
        check("e_frame_cnt", frame_cnt, 1);
        check("e_line_cnt", line_cnt, 0);
        check("e_q_empty", exp_q.size(), 0);
        @(negedge clock);

        // Asynchronous reset inside a start window
        n_frames = 8'd0;
        run = 1'b1;
        wait_line_start("r_line2", 2, 200);
        #2;
        reset = 1'b1;
        #1;
        check("r_gen_start", gen_start, 0);
        check("r_busy", busy, 0);
        check("r_err", err, 0);
        check("r_line_cnt", line_cnt, 0);
        check("r_frame_cnt", frame_cnt, 0);
        check("r_pat_sel", pat_sel, 0);
        check("r_first_line", first_line, 0);
        check("r_frame_done", frame_done, 0);
        run = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_frames = 8'd1;
        pat_sel_in = 2'd1;
        exp_q.push_back({8'd1, 2'd1});
        run = 1'b1;
        wait_line_start("r_restart", 0, 50);
        check("r_restart_first_line", first_line, 1);
        wait_idle("r_idle", 3000);
        check("r_q_empty", exp_q.size(), 0);
        run = 1'b0;
        @(negedge clock);

        // Continuous run across the frame counter wrap
        n_frames = 8'd0;
        pat_sel_in = 2'd1;
        for (int i = 1; i <= 258; i++) exp_q.push_back({8'(i), 2'd1});
        run = 1'b1;
        seen = 0;
        for (int k = 0; k < 60000 && seen < 257; k++) begin
            @(negedge clock);
            if (frame_done) seen++;
        end
        check("w_257_frames", seen, 257);
        run = 1'b0;
        wait_idle("w_idle", 2000);
        check("w_frame_cnt", frame_cnt, 2);
        check("w_q_empty", exp_q.size(), 0);
        check("w_line_max", line_max, AL - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
